pc_gen: RTL

Parametrised program-counter generator for the fetch stage. It supersedes the fixed-increment PC register and adds:
- a configurable address width, instruction size and reset vector;
- a branch/jump redirect input;
- a flush (exception/interrupt) redirect input that takes priority over everything;
- a one-entry hold buffer that keeps a branch target arriving during a fetch stall until the stall releases.

It drives the instruction-memory address (`pc`) and chip enable (`ce`) consumed by the fetch/IF-ID boundary.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_redirect_hold.sv | 31 +++
 rtl/pc_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants for the fetch-stage program-counter generator
package pc_pkg;

    localparam logic [1:0] S_RESET = 2'b00;
    localparam logic [1:0] S_START = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_hold.sv
// rtl/pc_redirect_hold.sv - one-entry buffer holding a branch target across a fetch stall
module pc_redirect_hold #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] data_in,
    output logic [ADDR_W-1:0] data_out,
    output logic              valid
);

    logic [ADDR_W-1:0] target;

    // clear wins so a flush in the same cycle as a load leaves the buffer empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid  <= 1'b1;
            target <= data_in;
        end
    end

    assign data_out = target;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with branch, flush and stall-held redirect
module pc_gen
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
    parameter int                STALL_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pending
);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] held_target;
    logic              held_valid;
    logic              hold_load;
    logic              hold_clear;
    logic              fetch_stall;
    logic              unused_stall;

    assign fetch_stall  = stall[0];
    assign unused_stall = ^stall;
    assign pc_seq       = pc + ADDR_W'(INST_BYTES);

    always_comb begin
        state_next = state;
        case (state)
            S_RESET: state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RESET;
        end else begin
            state <= state_next;
        end
    end

    // S_START advances past RESET_VEC but ignores redirects; S_RUN applies the full priority chain
    always_comb begin
        pc_next    = pc;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        case (state)
            S_START: begin
                if (fetch_stall == NO_STOP) begin
                    pc_next = pc_seq;
                end
            end
            S_RUN: begin
                if (flush) begin
                    pc_next    = flush_target;
                    hold_clear = 1'b1;
                end else if (fetch_stall == STOP) begin
                    hold_load = branch_flag;
                end else if (branch_flag) begin
                    pc_next    = branch_target;
                    hold_clear = 1'b1;
                end else if (held_valid) begin
                    pc_next    = held_target;
                    hold_clear = 1'b1;
                end else begin
                    pc_next = pc_seq;
                end
            end
            default: pc_next = RESET_VEC;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_VEC;
        end else begin
            pc <= pc_next;
        end
    end

    pc_redirect_hold #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .clear    (hold_clear),
        .data_in  (branch_target),
        .data_out (held_target),
        .valid    (held_valid)
    );

    assign ce               = (state == S_RESET) ? CHIP_DISABLE : CHIP_ENABLE;
    assign redirect_pending = held_valid;

endmodule
